peripheral_decoder: RTL

Receive-side counterpart of the client's keyboard/mouse uplink. It sits behind the network receive path on the host-side FPGA and consumes the framed payload byte stream produced by the client. Keyboard frames are 3 bytes: E0 flag, F0 flag, scan code. Mouse frames are 4 bytes: status, X, Y, Z. It reconstructs discrete key events and decoded mouse motion/button events, and flags malformed, aborted or stalled frames.

---
 rtl/peripheral_decoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/peripheral_decoder.sv
// peripheral_decoder
//   Rebuilds keyboard and mouse events from the framed uplink byte stream.
//   Keyboard frame: E0 flag, F0 flag, scan code (3 bytes).
//   Mouse frame:    status, X, Y, Z (4 bytes).
//   Malformed, aborted (new SOF mid-frame) or stalled frames pulse frame_error.
//
// Ports
//   clk, reset                   clock, async active-high reset
//   rx_valid/rx_sof/rx_kind      byte strobe, start-of-frame, frame kind (1=mouse)
//   rx_data[7:0]                 payload byte
//   key_valid, key_code,
//   key_extended, key_release    decoded key event (pulse + held data)
//   mouse_valid, mouse_buttons,
//   mouse_dx/dy/dz, mouse_ovf    decoded mouse event (pulse + held data)
//   frame_error                  pulse per dropped/rejected frame or stray byte
//   key_count, mouse_count       accepted event counters (wrapping)
module peripheral_decoder #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic       rx_sof,
  input  logic       rx_kind,
  input  logic [7:0] rx_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       mouse_valid,
  output logic [2:0] mouse_buttons,
  output logic [8:0] mouse_dx,
  output logic [8:0] mouse_dy,
  output logic [7:0] mouse_dz,
  output logic [1:0] mouse_ovf,
  output logic       frame_error,
  output logic [15:0] key_count,
  output logic [15:0] mouse_count
);

  typedef enum logic [1:0] {IDLE, KEY, MOUSE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [7:0]  byte0, byte1, byte2;
  logic        st0, st1, st2;
  logic        key_ok, mouse_ok, err;
  logic        key_legal;

  assign key_legal = ((byte0 == 8'h00) || (byte0 == 8'hE0)) &&
                     ((byte1 == 8'h00) || (byte1 == 8'hF0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = 16'd0;
    st0       = 1'b0;
    st1       = 1'b0;
    st2       = 1'b0;
    key_ok    = 1'b0;
    mouse_ok  = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt = 2'd0;
        if (rx_valid) begin
          if (rx_sof) begin
            st0       = 1'b1;
            idx_nxt   = 2'd1;
            state_nxt = rx_kind ? MOUSE : KEY;
          end else begin
            err = 1'b1;
          end
        end
      end
      KEY, MOUSE: begin
        if (rx_valid && rx_sof) begin
          // Restart: drop the partial frame, this byte opens the new one.
          err       = 1'b1;
          st0       = 1'b1;
          idx_nxt   = 2'd1;
          state_nxt = rx_kind ? MOUSE : KEY;
        end else if (rx_valid) begin
          if (state == KEY) begin
            if (idx == 2'd1) begin
              st1     = 1'b1;
              idx_nxt = 2'd2;
            end else begin
              key_ok    = key_legal;
              err       = !key_legal;
              idx_nxt   = 2'd0;
              state_nxt = IDLE;
            end
          end else begin
            if (idx == 2'd1) begin
              st1     = 1'b1;
              idx_nxt = 2'd2;
            end else if (idx == 2'd2) begin
              st2     = 1'b1;
              idx_nxt = 2'd3;
            end else begin
              mouse_ok  = byte0[3];
              err       = !byte0[3];
              idx_nxt   = 2'd0;
              state_nxt = IDLE;
            end
          end
        end else if (cnt == TIMEOUT - 16'd1) begin
          // TIMEOUT idle edges since the last byte: abort.
          err       = 1'b1;
          idx_nxt   = 2'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= 2'd0;
      cnt           <= 16'd0;
      byte0         <= 8'h00;
      byte1         <= 8'h00;
      byte2         <= 8'h00;
      key_valid     <= 1'b0;
      key_code      <= 8'h00;
      key_extended  <= 1'b0;
      key_release   <= 1'b0;
      mouse_valid   <= 1'b0;
      mouse_buttons <= 3'd0;
      mouse_dx      <= 9'd0;
      mouse_dy      <= 9'd0;
      mouse_dz      <= 8'h00;
      mouse_ovf     <= 2'd0;
      frame_error   <= 1'b0;
      key_count     <= 16'd0;
      mouse_count   <= 16'd0;
    end else begin
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      key_valid   <= key_ok;
      mouse_valid <= mouse_ok;
      frame_error <= err;
      if (st0) byte0 <= rx_data;
      if (st1) byte1 <= rx_data;
      if (st2) byte2 <= rx_data;
      if (key_ok) begin
        key_code     <= rx_data;
        key_extended <= (byte0 == 8'hE0);
        key_release  <= (byte1 == 8'hF0);
        key_count    <= key_count + 16'd1;
      end
      if (mouse_ok) begin
        mouse_buttons <= byte0[2:0];
        mouse_dx      <= {byte0[4], byte1};
        mouse_dy      <= {byte0[5], byte2};
        mouse_dz      <= rx_data;
        mouse_ovf     <= {byte0[7], byte0[6]};
        mouse_count   <= mouse_count + 16'd1;
      end
    end
  end

endmodule
